// File: rtl/conv_output_writer.sv
// conv_output_writer: packs convolution result pixels into little-endian
// memory words and issues one write request per word, walking a single
// output frame row by row. Each row ends with a partial word when the row
// width is not a multiple of the word size.
//
// state | meaning
// IDLE  | waiting for start after reset
// FILL  | accepting pixels into the lane buffer
// WRITE | word latched, write request pending until acknowledged
// DONE  | whole frame written, done held high until the next start
module conv_output_writer #(
  parameter int          PIXEL_WIDTH     = 16,
  parameter int          PIXELS_PER_WORD = 4,
  parameter int          OUT_WIDTH       = 63,
  parameter int          OUT_HEIGHT      = 31,
  parameter int          ROW_STRIDE      = 128,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clk_en,
  input  logic                                   start,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [PIXEL_WIDTH-1:0]                 in_pixel,
  output logic                                   de_req,
  input  logic                                   de_ack,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] de_w_data,
  output logic [31:0]                            de_addr,
  output logic [3:0]                             de_nbyte,
  output logic                                   done
);

  localparam int DATA_W     = PIXEL_WIDTH * PIXELS_PER_WORD;
  localparam int PIX_BYTES  = PIXEL_WIDTH / 8;
  localparam int WORD_BYTES = DATA_W / 8;
  localparam int LANE_W     = $clog2(PIXELS_PER_WORD + 1);
  localparam int COL_W      = $clog2(OUT_WIDTH + 1);
  localparam int ROW_W      = $clog2(OUT_HEIGHT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [LANE_W-1:0]   lane_cnt;
  logic [COL_W-1:0]    col;
  logic [COL_W-1:0]    word_idx;
  logic [ROW_W-1:0]    row;
  logic [DATA_W-1:0]   pix_buf;

  logic [DATA_W-1:0]   word_fill;
  logic [LANE_W-1:0]   lane_nxt;
  logic [COL_W-1:0]    col_nxt;
  logic                word_done;
  logic                row_end;
  logic                last_row;
  logic [31:0]         addr_calc;
  logic [3:0]          nbyte_calc;

  // Next-word view: current buffer with the incoming pixel placed in its lane,
  // plus the address and byte count the word will carry if it closes now.
  always_comb begin
    word_fill = pix_buf;
    for (int k = 0; k < PIXELS_PER_WORD; k++) begin
      if (lane_cnt == LANE_W'(k)) begin
        word_fill[k*PIXEL_WIDTH +: PIXEL_WIDTH] = in_pixel;
      end
    end
    lane_nxt   = lane_cnt + LANE_W'(1);
    col_nxt    = col + COL_W'(1);
    word_done  = (lane_nxt == LANE_W'(PIXELS_PER_WORD)) || (col_nxt == COL_W'(OUT_WIDTH));
    row_end    = (col == COL_W'(OUT_WIDTH));
    last_row   = (row == ROW_W'(OUT_HEIGHT - 1));
    addr_calc  = BASE_ADDR + 32'(row) * 32'(ROW_STRIDE) + 32'(word_idx) * 32'(WORD_BYTES);
    nbyte_calc = 4'(32'(lane_nxt) * 32'(PIX_BYTES));
  end

  // Frame sequencer: state, counters, lane buffer and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lane_cnt  <= '0;
      col       <= '0;
      word_idx  <= '0;
      row       <= '0;
      pix_buf   <= '0;
      in_ready  <= 1'b0;
      de_req    <= 1'b0;
      de_w_data <= '0;
      de_addr   <= '0;
      de_nbyte  <= '0;
      done      <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= FILL;
            lane_cnt <= '0;
            col      <= '0;
            word_idx <= '0;
            row      <= '0;
            pix_buf  <= '0;
            in_ready <= 1'b1;
            done     <= 1'b0;
          end
        end

        FILL: begin
          if (in_valid) begin
            lane_cnt <= lane_nxt;
            col      <= col_nxt;
            if (word_done) begin
              // Buffer is cleared so the next word starts with zeroed upper lanes.
              pix_buf   <= '0;
              de_w_data <= word_fill;
              de_addr   <= addr_calc;
              de_nbyte  <= nbyte_calc;
              de_req    <= 1'b1;
              in_ready  <= 1'b0;
              state     <= WRITE;
            end else begin
              pix_buf <= word_fill;
            end
          end
        end

        WRITE: begin
          if (de_ack) begin
            de_req   <= 1'b0;
            lane_cnt <= '0;
            if (row_end) begin
              col      <= '0;
              word_idx <= '0;
              row      <= row + ROW_W'(1);
            end else begin
              word_idx <= word_idx + COL_W'(1);
            end
            if (row_end && last_row) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          de_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_output_writer.sv
// Directed bench for conv_output_writer: full frames under three handshake
// regimes, plus reset behaviour before start and in the middle of a write.
module tb_conv_output_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_pixel = '0;
  logic        de_req;
  logic        de_ack = 1'b0;
  logic [63:0] de_w_data;
  logic [31:0] de_addr;
  logic [3:0]  de_nbyte;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int WORDS_PER_FRAME = 496;
  localparam int PIX_PER_FRAME   = 63 * 31;

  conv_output_writer dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .de_req    (de_req),
    .de_ack    (de_ack),
    .de_w_data (de_w_data),
    .de_addr   (de_addr),
    .de_nbyte  (de_nbyte),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected word w of a frame whose first pixel is base (pixels increment).
  task automatic exp_word(input int w, input logic [15:0] base,
                          output logic [63:0] d, output logic [31:0] a,
                          output logic [3:0] n);
    int r, i, lanes;
    logic [15:0] p;
    r = w / 16;
    i = w % 16;
    lanes = (i == 15) ? 3 : 4;
    d = '0;
    for (int k = 0; k < lanes; k++) begin
      p = base + 16'(r * 63 + i * 4 + k);
      d[k*16 +: 16] = p;
    end
    a = 32'h1000 + 32'(r * 128) + 32'(i * 8);
    n = 4'(lanes * 2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete frame. ack_delay: extra request cycles before de_ack;
  // ce_mode: clk_en drops for 3 cycles in every request (ack held) and
  // periodically during fill.
  task automatic run_frame(input logic [15:0] base, input int ack_delay, input bit ce_mode);
    int widx = 0, pix_idx = 0, req_len = 0, cyc = 0, exp_len;
    bit prev_req = 0, rdy;
    logic [63:0] hd, ed;
    logic [31:0] ha, ea;
    logic [3:0]  hn, en;
    exp_len = ce_mode ? 4 : ack_delay + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_done_clr", done, 0);
    chk("start_rdy", in_ready, 1);
    while (widx < WORDS_PER_FRAME && cyc < 8000) begin
      if (de_req) begin
        if (!prev_req) begin
          exp_word(widx, base, ed, ea, en);
          chk("w_data", de_w_data, ed);
          chk("w_addr", de_addr, ea);
          chk("w_nbyte", de_nbyte, en);
          if (widx == 0 && base == 16'h0001) chk("w0_data_const", de_w_data, 64'h0004_0003_0002_0001);
          if (widx == 0) chk("w0_addr_const", de_addr, 32'h1000);
          if (widx == 15) begin
            chk("rowend_addr", de_addr, 32'h1078);
            chk("rowend_nbyte", de_nbyte, 6);
            chk("rowend_top_lane", de_w_data[63:48], 0);
          end
          if (widx == 16) chk("row1_addr", de_addr, 32'h1080);
          if (widx == WORDS_PER_FRAME - 1) begin
            chk("last_addr", de_addr, 32'h1F78);
            chk("last_nbyte", de_nbyte, 6);
          end
          hd = de_w_data; ha = de_addr; hn = de_nbyte;
          req_len = 0;
        end else begin
          chk("hold_data", de_w_data, hd);
          chk("hold_addr", de_addr, ha);
          chk("hold_nbyte", de_nbyte, hn);
        end
        chk("rdy_in_write", in_ready, 0);
        req_len++;
      end else if (prev_req) begin
        chk("req_len", req_len, exp_len);
        widx++;
      end
      prev_req = de_req;
      clk_en   = !(ce_mode && ((de_req && req_len <= 3) || (!de_req && (cyc % 7) == 3)));
      de_ack   = de_req && (req_len > ack_delay);
      in_valid = 1'b1;
      in_pixel = base + 16'(pix_idx);
      start    = (cyc == 50);
      rdy      = in_ready;
      @(posedge clk);
      if (rdy && clk_en) pix_idx++;
      #1;
      cyc++;
    end
    in_valid = 1'b0; de_ack = 1'b0; start = 1'b0; clk_en = 1'b1;
    chk("frame_timeout", cyc < 8000, 1);
    chk("word_count", widx, WORDS_PER_FRAME);
    chk("pix_count", pix_idx, PIX_PER_FRAME);
    chk("done_set", done, 1);
    chk("done_no_req", de_req, 0);
    chk("done_no_rdy", in_ready, 0);
  endtask

  initial begin
    // Reset and idle behaviour.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_rdy", in_ready, 0);
    chk("rst_req", de_req, 0);
    chk("rst_data", de_w_data, 0);
    chk("rst_addr", de_addr, 0);
    chk("rst_nbyte", de_nbyte, 0);
    chk("rst_done", done, 0);
    de_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("idle_no_rdy", in_ready, 0);
      chk("idle_no_req", de_req, 0);
    end
    de_ack = 1'b0;

    run_frame(16'h0001, 0, 1'b0);
    run_frame(16'h0100, 5, 1'b0);
    run_frame(16'h7000, 0, 1'b1);

    // Reset between edges while a request is pending.
    begin
      int guard = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_pixel = 16'hABCD;
      while (!de_req && guard < 20) begin
        tick();
        guard++;
      end
      chk("midrst_req_seen", de_req, 1);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1 chk("midrst_req_drop", de_req, 0);
      chk("midrst_done", done, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
      chk("postrst_req", de_req, 0);
      chk("postrst_rdy", in_ready, 0);
      chk("postrst_done", done, 0);
      chk("postrst_data", de_w_data, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("postrst_start_rdy", in_ready, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
